io_uart_tx: RTL and testbench
=============================

# io_uart_tx

Memory-mapped UART transmitter that sits directly downstream of the core's `io_o` output register. Software sends a byte by storing a word to an IO address (bit 31 = 0) with a new byte in bits [7:0] and bit 8 toggled. This block detects the toggle, queues the byte in a small FIFO and serialises it as 8N1 on `tx`. It runs on the raw board clock `clk_`, not on the divided core clock.

## Interface
- `DIV`, 226: baud divisor in `clk_` cycles per bit (26 MHz / 115200). Legal range 2..65535.
- `DEPTH`, 8: FIFO depth in bytes. Must be a power of two, at least 2.
- `clk_  in  1`: board clock. All state updates on its rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `io_o  in  32`: the core's IO register.
  - [7:0] is the data byte.
  - [8] is the send toggle.
  - [31:9] are ignored.
- `tx  out  1`: serial line, idle high.
- `busy  out  1`: high while a frame is on the line or the FIFO is non-empty.
- `full  out  1`: FIFO holds `DEPTH` bytes.
- `overflow  out  1`: sticky. Set when a byte is dropped because the FIFO is full. Cleared only by `rst`.

## Operation
- Toggle detect:
  - `tog_q` registers `io_o[8]` every cycle.
  - A push event occurs in any cycle where `io_o[8] != tog_q`.
  - On that edge, `io_o[7:0]` is written to the FIFO.
- One event is produced per toggle. A held value produces no repeat events.
- The FIFO is first-word-fall-through, with pointers of width log2(DEPTH)+1 so that full and empty are distinguishable.
- Push when full:
  - With no pop in the same cycle, the byte is dropped and `overflow` is set.
  - With a pop in the same cycle, the push is accepted and the count is unchanged.
- Push when empty with no pop: the count becomes 1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, drive `tx`<=0, load the baud counter with DIV-1, and go to START.
  - START: when the counter reaches 0, drive `tx`<=shift[0], set bit index 0, reload the counter, and go to DATA.
  - DATA: when the counter reaches 0:
    - if index < 7: shift right, increment the index, drive `tx`<=next bit, and reload the counter;
    - if index == 7: drive `tx`<=1, reload the counter, and go to STOP.
  - STOP: when the counter reaches 0:
    - if the FIFO is non-empty, pop and go directly to START with `tx`<=0 (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Bits are sent LSB first. `tx` is driven from a flop, so it has no glitches.
- The baud counter has 16 bits, counts down, and reloads with DIV-1.
- `busy` = (state != IDLE) || !empty, taken from registered state and registered pointers.
- `full` comes from the registered pointers.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `full`=0, `overflow`=0.
  - State = IDLE, FIFO empty, `tog_q`=0, counters = 0.
- The core's `io_o` also resets to 0, so no spurious event occurs after reset.
- Push latency: on the edge where `io_o[8]` differs from `tog_q`, the byte enters the FIFO.
- On the next edge, IDLE pops the byte and `tx` falls. So `tx` falls 2 `clk_` edges after `io_o` changes.
- Each bit, including start and stop, lasts exactly DIV cycles. A frame is 10×DIV cycles.
- After a stop bit, the next queued frame's start bit begins on the following edge.
- `busy` goes low on the edge the FSM enters IDLE with the FIFO empty.
- `rst` mid-frame:
  - `tx` returns to 1 immediately (asynchronous).
  - The FIFO is flushed and the partial frame is abandoned.
- `io_o` changes at most once per core clock, which is far slower than `clk_`. A single register stage is sufficient because both clocks derive from `clk_`.

## Structure
- Package `uart_pkg` holds:
  - typedef `tx_state_t` (IDLE, START, DATA, STOP);
  - constant `DEFAULT_DIV` = 226;
  - constant `FRAME_BITS` = 10.
- Sub-module `sync_fifo`, parameterised on WIDTH=8 and DEPTH, with ports `push`, `pop`, `din`, `dout`, `empty`, `full`, `drop`. `io_uart_tx` instantiates it once.
- The FSM, baud counter, bit index, shift register and toggle detector live in `io_uart_tx`.

## Test plan
All scenarios use DIV=4 and DEPTH=4.
- Single byte: after reset, set `io_o`=0x0000_0155.
  - `tx` falls 2 edges later.
  - Line sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles (40 cycles total).
  - `busy` is low afterward.
- No repeat: hold `io_o`=0x155 for 200 cycles → exactly one frame is sent.
  - Then set `io_o`=0x0A5 (toggle back) → a second frame with data 0xA5 is sent.
- Back-to-back: issue 3 toggles with bytes 0x01, 0x02, 0x03, spaced 6 cycles apart.
  - Three frames are sent with no idle cycles between the stop and next start bits.
  - Total time from the first `tx` fall to the final idle is 120 cycles.
- Overflow: issue 6 toggles within 12 cycles while frame 1 is active.
  - `full` asserts and `overflow` becomes 1.
  - Exactly 5 bytes are transmitted: one in flight plus 4 queued.
  - The 6th byte is absent from the output.
- Simultaneous push/pop at full: with the FIFO full, time a toggle to coincide with the STOP→START pop.
  - The byte is accepted and `overflow` stays 0.
- Reset mid-frame: assert `rst` during DATA bit 3.
  - `tx`=1 and `busy`=0 within the same cycle.
  - After release, no residual frame is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the IO-mapped UART transmitter.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int unsigned DEFAULT_DIV = 226;
  localparam int unsigned FRAME_BITS  = 10;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO. An extra pointer bit tells full apart from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             drop
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full is still taken.
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;
    dout    = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk_ or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/io_uart_tx.sv
// 8N1 UART transmitter fed by toggle-strobed writes to the core IO register.
module io_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DIV   = DEFAULT_DIV,
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk_,
  input  logic        rst,
  input  logic [31:0] io_o,
  output logic        tx,
  output logic        busy,
  output logic        full,
  output logic        overflow
);
  localparam logic [15:0] RELOAD = 16'(DIV - 1);

  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        tog_q, ovf_q;
  logic        push, pop, empty, drop;
  logic [7:0]  head;
  logic        unused_io;

  always_comb unused_io = ^io_o[31:9];
  always_comb push = io_o[8] ^ tog_q;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk_  (clk_),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (io_o[7:0]),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .drop  (drop)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          cnt_d   = RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          cnt_d   = RELOAD;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          if (idx_q != 3'd7) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
          end else begin
            tx_d    = 1'b1;
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next start bit when more bytes are queued.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            cnt_d   = RELOAD;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_ or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      tog_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      tog_q   <= io_o[8];
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    tx       = tx_q;
    busy     = (state_q != IDLE) || !empty;
    overflow = ovf_q;
  end
endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx with DIV=4, DEPTH=4; line sampled on falling clock edges.
module tb_io_uart_tx;
  import uart_pkg::*;

  localparam int unsigned DIV   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME_CYC = FRAME_BITS * DIV;

  logic        clk_ = 1'b0;
  logic        rst  = 1'b1;
  logic [31:0] io_o = '0;
  logic        tx, busy, full, overflow;

  io_uart_tx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk_     (clk_),
    .rst      (rst),
    .io_o     (io_o),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk_ = ~clk_;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // bit i = line level during bit period i (start first)
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic        tog   = 1'b0;
  logic [22:0] hi    = 23'h15A5A5;
  bit          cap_q[$];
  bit          exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    tog  = ~tog;
    hi   = ~hi;
    io_o = {hi, tog, d};
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    io_o = '0;
    tog  = 1'b0;
    repeat (3) @(negedge clk_);
    rst = 1'b0;
  endtask

  task automatic wait_fall(input int unsigned max, output int unsigned n);
    n = 0;
    for (int unsigned i = 1; i <= max; i++) begin
      @(negedge clk_);
      if (tx === 1'b0) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic capture(input int unsigned n);
    cap_q.delete();
    cap_q.push_back(tx);
    for (int unsigned i = 1; i < n; i++) begin
      @(negedge clk_);
      cap_q.push_back(tx);
    end
  endtask

  task automatic exp_frame(input logic [9:0] line);
    for (int unsigned b = 0; b < 10; b++)
      for (int unsigned c = 0; c < DIV; c++)
        exp_q.push_back(line[b]);
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  task automatic cmp_line(input string name);
    bit          ok;
    int unsigned first;
    ok    = (cap_q.size() == exp_q.size());
    first = 0;
    if (ok) begin
      for (int unsigned i = 0; i < cap_q.size(); i++) begin
        if (cap_q[i] !== exp_q[i]) begin
          ok    = 1'b0;
          first = i;
          break;
        end
      end
    end
    total++;
    if (!ok) begin
      bad++;
      if (cap_q.size() == exp_q.size())
        $display("FAIL %s: sample %0d got=%0b exp=%0b", name, first, cap_q[first], exp_q[first]);
      else
        $display("FAIL %s: length got=%0d exp=%0d", name, cap_q.size(), exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic quiet(input int unsigned n, input string name);
    int unsigned falls;
    falls = 0;
    repeat (n) begin
      @(negedge clk_);
      if (tx === 1'b0) falls++;
    end
    chk(name, falls, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t        vecs[6];
    logic [7:0]  ov[6];
    logic [7:0]  sp[6];
    int unsigned n;

    vecs[0] = '{8'h55, 10'h2AA};
    vecs[1] = '{8'hA5, 10'h34A};
    vecs[2] = '{8'h00, 10'h200};
    vecs[3] = '{8'hFF, 10'h3FE};
    vecs[4] = '{8'h80, 10'h300};
    vecs[5] = '{8'h01, 10'h202};
    ov = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
    sp = '{8'hC3, 8'h3C, 8'h96, 8'h69, 8'hE1, 8'h1E};

    do_reset();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk_);

    // Single frames, each followed by a long hold that must not re-trigger
    for (int unsigned i = 0; i < 6; i++) begin
      send(vecs[i].data);
      wait_fall(20, n);
      chk("latency", n, 2);
      capture(FRAME_CYC);
      exp_frame(vecs[i].line);
      cmp_line("frame");
      @(negedge clk_);
      chk("busy_after_frame", busy, 0);
      quiet(100, "no_repeat");
      io_o[31:9] = ~io_o[31:9];
      quiet(100, "upper_bits_ignored");
    end

    // Back-to-back: three bytes 6 cycles apart, no gap between frames
    fork
      begin
        send(8'h01);
        repeat (6) @(negedge clk_);
        send(8'h02);
        repeat (6) @(negedge clk_);
        send(8'h03);
      end
      begin
        wait_fall(20, n);
        chk("b2b_latency", n, 2);
        capture(3 * FRAME_CYC);
      end
    join
    exp_frame(frame_of(8'h01));
    exp_frame(frame_of(8'h02));
    exp_frame(frame_of(8'h03));
    cmp_line("b2b_line");
    chk("b2b_busy_last", busy, 1);
    @(negedge clk_);
    chk("b2b_busy_idle", busy, 0);

    // Overflow: six toggles 2 cycles apart while the first frame is on the line
    do_reset();
    @(negedge clk_);
    fork
      begin
        send(ov[0]);
        for (int unsigned k = 1; k < 6; k++) begin
          repeat (2) @(negedge clk_);
          send(ov[k]);
        end
        @(negedge clk_);
        chk("ovf_full", full, 1);
        chk("ovf_set", overflow, 1);
      end
      begin
        wait_fall(20, n);
        capture(5 * FRAME_CYC);
      end
    join
    for (int unsigned k = 0; k < 5; k++) exp_frame(frame_of(ov[k]));
    cmp_line("ovf_line");
    @(negedge clk_);
    chk("ovf_busy_idle", busy, 0);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_full_clear", full, 0);
    quiet(60, "ovf_sixth_absent");

    // Push coinciding with the STOP->START pop while full
    do_reset();
    @(negedge clk_);
    fork
      begin
        send(sp[0]);
        for (int unsigned k = 1; k < 5; k++) begin
          repeat (2) @(negedge clk_);
          send(sp[k]);
        end
        @(negedge clk_);
        chk("sp_full_before", full, 1);
        repeat (32) @(negedge clk_);
        chk("sp_ovf_before", overflow, 0);
        send(sp[5]);
        @(negedge clk_);
        chk("sp_ovf_after", overflow, 0);
        chk("sp_full_after", full, 1);
      end
      begin
        wait_fall(20, n);
        capture(6 * FRAME_CYC);
      end
    join
    for (int unsigned k = 0; k < 6; k++) exp_frame(frame_of(sp[k]));
    cmp_line("sp_line");
    @(negedge clk_);
    chk("sp_busy_idle", busy, 0);

    // Reset during data bit 3 of a 0x00 frame
    do_reset();
    @(negedge clk_);
    send(8'h00);
    wait_fall(20, n);
    chk("mid_latency", n, 2);
    repeat (17) @(negedge clk_);
    chk("mid_tx_low", tx, 0);
    rst  = 1'b1;
    io_o = '0;
    tog  = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk_);
    rst = 1'b0;
    quiet(100, "mid_no_residual");
    chk("mid_busy_after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
